icache_mshr_txreq_arbiter: RTL and testbench
============================================

Name: icache_mshr_txreq_arbiter

Overview:
Shares the single downstream request channel among all icache MSHR entries. Each entry in its downstream-request state raises a request; this block picks one entry per cycle with round-robin arbitration and returns a one-cycle release/ready pulse to the winner. It registers the winning payload into a one-deep output slot toward the downstream bus. It also bounds in-flight linefills with a credit counter that is returned on linefill completion.

Parameters:
ENTRY_NUM, 8, number of MSHR entries (matches MSHR_ENTRY_NUM)
CREDIT_NUM, 4, maximum downstream requests outstanding (issued, linefill not done)
PLD_WIDTH, 42, flattened pc_req_t width (addr 32 + txnid 5 + opcode 5)
ID_WIDTH, 3, entry-id width, equal to clog2(ENTRY_NUM)
CNT_WIDTH, 3, credit-counter width, equal to clog2(CREDIT_NUM+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high; the name follows the codebase convention, and the polarity is fixed
entry_txreq_vld  in  ENTRY_NUM  per-entry downstream request valid
entry_txreq_pld  in  ENTRY_NUM*PLD_WIDTH  per-entry payload; entry i occupies bits [i*PLD_WIDTH +: PLD_WIDTH]
entry_txreq_rdy  out  ENTRY_NUM  one-hot grant; the entry's downstream_txreq_rdy
entry_release_en  out  ENTRY_NUM  equal to entry_txreq_rdy; the entry's downstream_release_en
downstream_txreq_vld  out  1  output slot valid
downstream_txreq_rdy  in  1  downstream accept
downstream_txreq_pld  out  PLD_WIDTH  output slot payload
downstream_txreq_entry_id  out  ID_WIDTH  index of the entry that owns the slot
linefill_done  in  1  one-cycle pulse when one linefill completes; returns one credit
credit_cnt  out  CNT_WIDTH  available credits
outstanding_cnt  out  CNT_WIDTH  equal to CREDIT_NUM - credit_cnt
credit_err  out  1  sticky error: linefill_done arrived while credit_cnt == CREDIT_NUM

Behaviour:
- Reset (rst_n == 1 at a clock edge):
  - rr_ptr = 0, slot empty.
  - downstream_txreq_vld = 0, downstream_txreq_pld = 0, downstream_txreq_entry_id = 0.
  - credit_cnt = CREDIT_NUM, credit_err = 0.
  - entry_txreq_rdy and entry_release_en are 0 while rst_n is high.
  - A reset mid-operation drops any slot contents and restores all credits; no grant is issued in the reset cycle.
- Slot free condition (combinational): slot_free = ~downstream_txreq_vld | downstream_txreq_rdy. The slot refills in the same cycle it drains.
- Grant eligibility: |entry_txreq_vld & slot_free & (credit_cnt != 0).
- Winner selection: the first i with entry_txreq_vld[i] set, searching from rr_ptr upward and wrapping modulo ENTRY_NUM.
- Grant outputs: entry_txreq_rdy = entry_release_en = one-hot(winner) in the same cycle, combinational. All bits are 0 when there is no grant.
- Grant latency: the entry sees rdy and release_en together for exactly one cycle. It leaves its request state on the next edge, so a given entry can never win two consecutive cycles.
- On a grant edge:
  - slot payload <= entry_txreq_pld[winner], entry_id <= winner, downstream_txreq_vld <= 1.
  - rr_ptr <= (winner + 1) mod ENTRY_NUM.
  - Latency is 1 cycle from grant to downstream_txreq_vld.
- Drain without refill (slot_free and no grant): downstream_txreq_vld <= 0; payload is held.
- Stall (vld & ~rdy): payload and entry_id stay stable and no grant is issued.
- rr_ptr is unchanged on cycles with no grant.
- Credit counter:
  - Grant only: decrement by 1.
  - linefill_done only: increment by 1.
  - Both in the same cycle: unchanged.
  - Increment saturates at CREDIT_NUM; an increment attempted at CREDIT_NUM sets credit_err, which stays set until reset.
  - Decrement cannot underflow because grants are gated by credit_cnt != 0.
- Throughput: 1 request per cycle when rdy is held high and credits are available.
- Payload is passed through unmodified. The opcode is not interpreted here.

Test Plan:
- Single request: entries 0..7 idle, entry 2 raises vld with pld addr 0x0000_1040 / txnid 5 / opcode 1 → rdy[2] = 1 that cycle; next cycle downstream_txreq_vld = 1, pld matches, entry_id = 2, credit_cnt = 3, rr_ptr = 3.
- Round robin: entries 1, 3, 6 request continuously, each dropping its request after its own grant, downstream rdy = 1, credits ample → grant order is 1, 3, 6. Re-raising 1 and 6 with rr_ptr = 7 → next order is 1, then 6.
- Backpressure: downstream rdy = 0 for 4 cycles with slot full and entry 5 requesting → no rdy[5] pulse and slot payload stable. When rdy rises, entry 5 is granted in that same cycle and the slot refills back-to-back.
- Credit exhaustion: CREDIT_NUM = 4, five entries request → 4 grants, then credit_cnt = 0 and the fifth is held. A linefill_done pulse → fifth is granted the next cycle.
- Simultaneous grant and linefill_done with credit_cnt = 2 → credit_cnt stays 2, outstanding_cnt = 2.
- Extra linefill_done at credit_cnt = 4 → credit_cnt stays 4 and credit_err = 1. Asserting rst_n with the slot full → vld = 0, credit_cnt = 4, credit_err = 0 after the edge.

Source files
------------

// File: rtl/icache_mshr_txreq_arbiter.sv
// Round-robin arbiter that funnels icache MSHR downstream requests into a one-deep
// output slot, with a credit counter bounding linefills that are still in flight.
module icache_mshr_txreq_arbiter #(
    parameter int ENTRY_NUM  = 8,
    parameter int CREDIT_NUM = 4,
    parameter int PLD_WIDTH  = 42,
    parameter int ID_WIDTH   = 3,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ENTRY_NUM-1:0]           entry_txreq_vld,
    input  logic [ENTRY_NUM*PLD_WIDTH-1:0] entry_txreq_pld,
    output logic [ENTRY_NUM-1:0]           entry_txreq_rdy,
    output logic [ENTRY_NUM-1:0]           entry_release_en,
    output logic                           downstream_txreq_vld,
    input  logic                           downstream_txreq_rdy,
    output logic [PLD_WIDTH-1:0]           downstream_txreq_pld,
    output logic [ID_WIDTH-1:0]            downstream_txreq_entry_id,
    input  logic                           linefill_done,
    output logic [CNT_WIDTH-1:0]           credit_cnt,
    output logic [CNT_WIDTH-1:0]           outstanding_cnt,
    output logic                           credit_err
);

    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDIT_NUM);

    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                 slot_vld_q, slot_vld_d;
    logic [PLD_WIDTH-1:0] slot_pld_q, slot_pld_d;
    logic [ID_WIDTH-1:0]  slot_id_q, slot_id_d;
    logic [CNT_WIDTH-1:0] credit_cnt_q, credit_cnt_d;
    logic                 credit_err_q, credit_err_d;

    logic                 found;
    logic [ID_WIDTH-1:0]  winner;
    logic [ID_WIDTH-1:0]  idx;
    logic                 slot_free;
    logic                 grant_en;
    logic [ENTRY_NUM-1:0] grant_oh;

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + k) % ENTRY_NUM);
            if (!found && entry_txreq_vld[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The slot refills in the same cycle it drains; no grants during reset.
    assign slot_free = ~slot_vld_q | downstream_txreq_rdy;
    assign grant_en  = found & slot_free & (credit_cnt_q != '0) & ~rst_n;

    always_comb begin
        grant_oh = '0;
        if (grant_en) grant_oh[winner] = 1'b1;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        slot_vld_d   = slot_vld_q;
        slot_pld_d   = slot_pld_q;
        slot_id_d    = slot_id_q;
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;

        if (grant_en) begin
            slot_vld_d = 1'b1;
            slot_pld_d = entry_txreq_pld[int'(winner)*PLD_WIDTH +: PLD_WIDTH];
            slot_id_d  = winner;
            rr_ptr_d   = ID_WIDTH'((int'(winner) + 1) % ENTRY_NUM);
        end else if (slot_free) begin
            slot_vld_d = 1'b0;
        end

        // A grant and a returned credit in the same cycle cancel out.
        if (grant_en && !linefill_done) begin
            credit_cnt_d = credit_cnt_q - 1'b1;
        end else if (linefill_done && !grant_en) begin
            if (credit_cnt_q == CREDIT_MAX) credit_err_d = 1'b1;
            else                            credit_cnt_d = credit_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rr_ptr_q     <= '0;
            slot_vld_q   <= 1'b0;
            slot_pld_q   <= '0;
            slot_id_q    <= '0;
            credit_cnt_q <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            slot_vld_q   <= slot_vld_d;
            slot_pld_q   <= slot_pld_d;
            slot_id_q    <= slot_id_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign entry_txreq_rdy           = grant_oh;
    assign entry_release_en          = grant_oh;
    assign downstream_txreq_vld      = slot_vld_q;
    assign downstream_txreq_pld      = slot_pld_q;
    assign downstream_txreq_entry_id = slot_id_q;
    assign credit_cnt                = credit_cnt_q;
    assign outstanding_cnt           = CREDIT_MAX - credit_cnt_q;
    assign credit_err                = credit_err_q;

endmodule

// File: tb/tb_icache_mshr_txreq_arbiter.sv
// Directed bench for icache_mshr_txreq_arbiter: a vector table for arbitration,
// backpressure and credits, plus hand sequences for exhaustion, error and reset.
module tb_icache_mshr_txreq_arbiter;

    localparam int EN = 8;
    localparam int PW = 42;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [EN-1:0]   entry_txreq_vld;
    logic [EN*PW-1:0] entry_txreq_pld;
    logic [EN-1:0]   entry_txreq_rdy;
    logic [EN-1:0]   entry_release_en;
    logic            downstream_txreq_vld;
    logic            downstream_txreq_rdy;
    logic [PW-1:0]   downstream_txreq_pld;
    logic [2:0]      downstream_txreq_entry_id;
    logic            linefill_done;
    logic [2:0]      credit_cnt;
    logic [2:0]      outstanding_cnt;
    logic            credit_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_mshr_txreq_arbiter dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .entry_txreq_vld           (entry_txreq_vld),
        .entry_txreq_pld           (entry_txreq_pld),
        .entry_txreq_rdy           (entry_txreq_rdy),
        .entry_release_en          (entry_release_en),
        .downstream_txreq_vld      (downstream_txreq_vld),
        .downstream_txreq_rdy      (downstream_txreq_rdy),
        .downstream_txreq_pld      (downstream_txreq_pld),
        .downstream_txreq_entry_id (downstream_txreq_entry_id),
        .linefill_done             (linefill_done),
        .credit_cnt                (credit_cnt),
        .outstanding_cnt           (outstanding_cnt),
        .credit_err                (credit_err)
    );

    typedef struct {
        logic [7:0] vld;
        logic       ds_rdy;
        logic       lf;
        logic [7:0] exp_rdy;
        logic       exp_vld;
        logic [2:0] exp_id;
        logic [2:0] exp_credit;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [PW-1:0] pld_of(input int i);
        logic [31:0] addr;
        addr = 32'h0000_1000 + 32'(i) * 32'h40;
        return {addr, 5'(i), 5'd1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, settle, leaving the caller to check combinational outputs.
    task automatic drive(input logic [7:0] vld, input logic ds_rdy, input logic lf, input logic rst);
        @(negedge clk);
        entry_txreq_vld      = vld;
        downstream_txreq_rdy = ds_rdy;
        linefill_done        = lf;
        rst_n                = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        drive(8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load_default_pld();
        for (int i = 0; i < EN; i++) entry_txreq_pld[i*PW +: PW] = pld_of(i);
    endtask

    initial begin
        // vld, ds_rdy, lf, exp_rdy, exp_vld, exp_id, exp_credit
        vecs[0]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd4};
        vecs[1]  = '{8'h4A, 1'b1, 1'b0, 8'h02, 1'b1, 3'd1, 3'd3};
        vecs[2]  = '{8'h48, 1'b1, 1'b0, 8'h08, 1'b1, 3'd3, 3'd2};
        vecs[3]  = '{8'h40, 1'b1, 1'b0, 8'h40, 1'b1, 3'd6, 3'd1};
        vecs[4]  = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd6, 3'd2};
        vecs[5]  = '{8'h42, 1'b1, 1'b0, 8'h02, 1'b1, 3'd1, 3'd1};
        vecs[6]  = '{8'h40, 1'b1, 1'b0, 8'h40, 1'b1, 3'd6, 3'd0};
        vecs[7]  = '{8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3'd6, 3'd0};
        vecs[8]  = '{8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 3'd6, 3'd1};
        vecs[9]  = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 3'd0};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 3'd0, 3'd1};
        vecs[11] = '{8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1};
        vecs[12] = '{8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1};
        vecs[13] = '{8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1};
        vecs[14] = '{8'h20, 1'b1, 1'b0, 8'h20, 1'b1, 3'd5, 3'd0};
        vecs[15] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd5, 3'd1};
        vecs[16] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd5, 3'd2};
        vecs[17] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd5, 3'd3};
        vecs[18] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd5, 3'd4};

        entry_txreq_vld      = '0;
        downstream_txreq_rdy = 1'b1;
        linefill_done        = 1'b0;
        rst_n                = 1'b1;
        load_default_pld();

        // Reset state, including grants held off while reset is asserted.
        drive(8'hFF, 1'b1, 1'b0, 1'b1);
        check("rst_rdy", 64'(entry_txreq_rdy), 64'h0);
        tick();
        check("rst_vld", 64'(downstream_txreq_vld), 64'h0);
        check("rst_pld", 64'(downstream_txreq_pld), 64'h0);
        check("rst_id", 64'(downstream_txreq_entry_id), 64'h0);
        check("rst_credit", 64'(credit_cnt), 64'd4);
        check("rst_outst", 64'(outstanding_cnt), 64'd0);
        check("rst_err", 64'(credit_err), 64'h0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        tick();

        // Vector table: round robin, wrap, credit gating, 4-cycle stall, refill on release.
        for (int v = 0; v < 19; v++) begin
            drive(vecs[v].vld, vecs[v].ds_rdy, vecs[v].lf, 1'b0);
            check($sformatf("v%0d_rdy", v), 64'(entry_txreq_rdy), 64'(vecs[v].exp_rdy));
            check($sformatf("v%0d_rel", v), 64'(entry_release_en), 64'(vecs[v].exp_rdy));
            tick();
            check($sformatf("v%0d_dvld", v), 64'(downstream_txreq_vld), 64'(vecs[v].exp_vld));
            check($sformatf("v%0d_id", v), 64'(downstream_txreq_entry_id), 64'(vecs[v].exp_id));
            check($sformatf("v%0d_credit", v), 64'(credit_cnt), 64'(vecs[v].exp_credit));
            check($sformatf("v%0d_outst", v), 64'(outstanding_cnt), 64'(3'd4 - vecs[v].exp_credit));
            if (vecs[v].exp_vld)
                check($sformatf("v%0d_pld", v), 64'(downstream_txreq_pld), 64'(pld_of(int'(vecs[v].exp_id))));
        end

        // Single request with a specific payload; rr_ptr = 3 afterwards picks 4 over 1.
        do_reset();
        entry_txreq_pld[2*PW +: PW] = {32'h0000_1040, 5'd5, 5'd1};
        drive(8'h04, 1'b1, 1'b0, 1'b0);
        check("single_rdy", 64'(entry_txreq_rdy), 64'h04);
        tick();
        check("single_vld", 64'(downstream_txreq_vld), 64'h1);
        check("single_pld", 64'(downstream_txreq_pld), 64'({32'h0000_1040, 5'd5, 5'd1}));
        check("single_id", 64'(downstream_txreq_entry_id), 64'd2);
        check("single_credit", 64'(credit_cnt), 64'd3);
        drive(8'h12, 1'b1, 1'b0, 1'b0);
        check("rrptr3_rdy", 64'(entry_txreq_rdy), 64'h10);
        tick();
        check("rrptr3_id", 64'(downstream_txreq_entry_id), 64'd4);
        load_default_pld();

        // Credit exhaustion: five requesters, four grants, fifth waits for linefill_done.
        do_reset();
        begin
            logic [7:0] mask;
            mask = 8'h1F;
            for (int k = 0; k < 4; k++) begin
                drive(mask, 1'b1, 1'b0, 1'b0);
                check($sformatf("exh%0d_rdy", k), 64'(entry_txreq_rdy), 64'(8'h01 << k));
                tick();
                mask[k] = 1'b0;
                check($sformatf("exh%0d_credit", k), 64'(credit_cnt), 64'(3 - k));
            end
        end
        drive(8'h10, 1'b1, 1'b0, 1'b0);
        check("exh_held_rdy", 64'(entry_txreq_rdy), 64'h0);
        tick();
        drive(8'h10, 1'b1, 1'b1, 1'b0);
        check("exh_lf_rdy", 64'(entry_txreq_rdy), 64'h0);
        tick();
        check("exh_lf_credit", 64'(credit_cnt), 64'd1);
        drive(8'h10, 1'b1, 1'b0, 1'b0);
        check("exh_fifth_rdy", 64'(entry_txreq_rdy), 64'h10);
        tick();
        check("exh_fifth_id", 64'(downstream_txreq_entry_id), 64'd4);
        check("exh_fifth_credit", 64'(credit_cnt), 64'd0);

        // Grant and linefill_done together at credit 2 leave the count unchanged.
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check("sim_pre_credit", 64'(credit_cnt), 64'd2);
        drive(8'h01, 1'b1, 1'b1, 1'b0);
        check("sim_rdy", 64'(entry_txreq_rdy), 64'h01);
        tick();
        check("sim_credit", 64'(credit_cnt), 64'd2);
        check("sim_outst", 64'(outstanding_cnt), 64'd2);

        // Extra linefill_done at full credit is sticky; reset clears it and the full slot.
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check("full_credit", 64'(credit_cnt), 64'd4);
        check("full_err0", 64'(credit_err), 64'h0);
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check("over_credit", 64'(credit_cnt), 64'd4);
        check("over_err", 64'(credit_err), 64'h1);
        drive(8'h08, 1'b0, 1'b0, 1'b0);
        check("pre_rst_rdy", 64'(entry_txreq_rdy), 64'h08);
        tick();
        check("pre_rst_vld", 64'(downstream_txreq_vld), 64'h1);
        check("err_sticky", 64'(credit_err), 64'h1);
        drive(8'hFF, 1'b0, 1'b0, 1'b1);
        check("mid_rst_rdy", 64'(entry_txreq_rdy), 64'h0);
        check("mid_rst_rel", 64'(entry_release_en), 64'h0);
        tick();
        check("mid_rst_vld", 64'(downstream_txreq_vld), 64'h0);
        check("mid_rst_credit", 64'(credit_cnt), 64'd4);
        check("mid_rst_err", 64'(credit_err), 64'h0);
        check("mid_rst_id", 64'(downstream_txreq_entry_id), 64'd0);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
